call_seq_ctrl: RTL and testbench
================================

# call_seq_ctrl

Sequencing controller for the handset/line datapath: conditions the raw `hooked`, `unhooked` and `write_mode` push inputs, commits `mode_in` on request, and runs the IDLE/ARMED/ACTIVE/DONE call sequence with a per-mode time limit. It sits between the board inputs and the 7-segment decode stage in `main`. It drives three 4-bit digit codes (mode, tens, units of elapsed seconds) that the existing decoders turn into `out_mode`, `out1_action` and `out2_action`.

## Interface
- `TICKS_PER_SEC`, 50_000_000: clock cycles per 1 s tick.
- `DEBOUNCE_TICKS`, 1_000_000: consecutive stable cycles required before a debounced level changes.
- `ARM_SEC`, 5: ARMED timeout, in seconds.
- `HOLD_SEC`, 3: DONE display time, in seconds.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `mode_in`  in  2  mode selection; sampled only on a commit.
- `write_mode`  in  1  raw commit button, asynchronous.
- `hooked`  in  1  raw start button, asynchronous.
- `unhooked`  in  1  raw release button, asynchronous.
- `state`  out  2  current state: 0 IDLE, 1 ARMED, 2 ACTIVE, 3 DONE.
- `mode_code`  out  4  {2'b00, committed mode}.
- `act1_code`  out  4  left digit code.
- `act2_code`  out  4  right digit code.
- `timeout`  out  1  high in DONE when the limit was reached.

## Operation
- **Input conditioning.** Each raw input passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level takes the synchronized value after it has been stable for `DEBOUNCE_TICKS` consecutive cycles.
  - The rising edge of the debounced level gives a 1-cycle event pulse. Falling edges give no event.
- **Event priority** when events coincide: unhooked > hooked > write_mode. Lower-priority events in the same cycle are dropped.
- **Prescaler.** Counts 0..`TICKS_PER_SEC`-1 and emits `tick` at the terminal count. It is cleared on every state transition.
- **Mode limits** (seconds): mode 0 none (`elapsed` saturates at 99); mode 1 = 10; mode 2 = 30; mode 3 = 60.
- **IDLE**
  - write_mode: `mode_q` <= `mode_in`, go to ARMED.
  - hooked: go to ACTIVE.
- **ARMED**
  - hooked: go to ACTIVE.
  - write_mode: re-latch `mode_q`, stay in ARMED, clear the second counter.
  - After `ARM_SEC` ticks: go to IDLE.
- **ACTIVE**
  - `elapsed` is cleared on entry and incremented by 1 on each tick (7-bit).
  - unhooked: go to DONE with `timeout`=0.
  - The tick that makes `elapsed` equal to the limit: go to DONE with `timeout`=1 on the same edge.
  - write_mode and hooked are ignored.
- **DONE**
  - After `HOLD_SEC` ticks: go to IDLE.
  - hooked: go to ACTIVE (`elapsed` cleared).
  - write_mode is ignored.
  - `timeout` clears on exit.
- **Digit codes**
  - IDLE: F,F (F = blank).
  - ARMED: A,A (A = dash).
  - ACTIVE and DONE: `elapsed`/10, `elapsed`%10.
- **Reset** at any time, including mid-sequence or mid-debounce:
  - state IDLE; `mode_q`=0; `elapsed`=0; prescaler=0.
  - Debouncers and synchronizers to 0.
  - Outputs: `state`=0, `mode_code`=0, `act1_code`=F, `act2_code`=F, `timeout`=0.
  - An input held high through reset produces its event only after a full debounce following the release of reset.

## Timing
- All outputs are registered.
- A raw input rising at cycle 0 and held reaches its debounced level at cycle `DEBOUNCE_TICKS`+2. The state update and all outputs are visible at cycle `DEBOUNCE_TICKS`+3.
- The first ACTIVE increment happens exactly `TICKS_PER_SEC` cycles after entering ACTIVE.
- The ARMED and DONE timeouts fire after exactly N×`TICKS_PER_SEC` cycles in the state.
- The digit codes update on the same edge as `elapsed`.

## Structure
- Package `call_ctrl_pkg` holds:
  - the state encoding;
  - the digit constants CODE_BLANK=4'hF and CODE_DASH=4'hA;
  - the mode-limit function (mode → seconds).
- Sub-module `in_debounce`: synchronizer, debounce counter and rising-edge pulse. It is instantiated three times.
- The FSM, prescaler, second counter and digit split stay in `call_seq_ctrl`.

## Test plan
All scenarios use `TICKS_PER_SEC`=10, `DEBOUNCE_TICKS`=4, `ARM_SEC`=3, `HOLD_SEC`=2.
- **Commit and arm timeout.** `mode_in`=1, write_mode high 8 cycles → 7 cycles after the rise: `state`=1, `mode_code`=1, codes A,A. 30 cycles later → `state`=0, codes F,F.
- **Glitch rejection.** hooked high 3 cycles in IDLE → no state change, no event.
- **Limit timeout.** `mode_in`=1, commit, then hooked → ACTIVE, codes 0,0. After 100 cycles → `state`=3, codes 1,0, `timeout`=1. 20 cycles later → IDLE, `timeout`=0.
- **Release.** Mode 0, hooked, then unhooked debounced after 5 ticks → `state`=3, codes 0,5, `timeout`=0.
- **Simultaneous events.** In ACTIVE, hooked and unhooked rise on the same cycle → DONE; `elapsed` not restarted.
- **Reset mid-sequence.** In ACTIVE with `elapsed`=7, pulse reset 1 cycle → next edge: `state`=0, `mode_code`=0, codes F,F, `timeout`=0.

Source files
------------

// File: rtl/call_ctrl_pkg.sv
// Shared types and constants for the call sequencing controller.
package call_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StActive = 2'd2,
        StDone   = 2'd3
    } call_state_e;

    localparam logic [3:0] CODE_BLANK  = 4'hF;
    localparam logic [3:0] CODE_DASH   = 4'hA;
    localparam logic [6:0] ELAPSED_MAX = 7'd99;

    // Zero means the mode has no time limit.
    function automatic logic [6:0] mode_limit(input logic [1:0] mode);
        case (mode)
            2'd1:    return 7'd10;
            2'd2:    return 7'd30;
            2'd3:    return 7'd60;
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/in_debounce.sv
// Two-flop synchronizer, debounce counter and rising-edge event pulse for one raw button.
module in_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int unsigned CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_prev_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            // Counter only runs while the synchronized value disagrees with the level.
            if (sync2_q != level_q) begin
                if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise = level_q & ~level_prev_q;

endmodule

// File: rtl/call_seq_ctrl.sv
// Call sequencing controller: conditioned button events drive IDLE/ARMED/ACTIVE/DONE with
// per-mode time limits and registered digit codes for the 7-segment decoders.
module call_seq_ctrl
    import call_ctrl_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC  = 50_000_000,
    parameter int unsigned DEBOUNCE_TICKS = 1_000_000,
    parameter int unsigned ARM_SEC        = 5,
    parameter int unsigned HOLD_SEC       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_in,
    input  logic       write_mode,
    input  logic       hooked,
    input  logic       unhooked,
    output logic [1:0] state,
    output logic [3:0] mode_code,
    output logic [3:0] act1_code,
    output logic [3:0] act2_code,
    output logic       timeout
);

    localparam int unsigned PW      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SEC_MAX = (ARM_SEC > HOLD_SEC) ? ARM_SEC : HOLD_SEC;
    localparam int unsigned SW      = (SEC_MAX > 1) ? $clog2(SEC_MAX + 1) : 1;

    logic wr_rise, hook_rise, unhook_rise;

    in_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_write (
        .clk   (clk),
        .reset (reset),
        .raw   (write_mode),
        .rise  (wr_rise)
    );

    in_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_hook (
        .clk   (clk),
        .reset (reset),
        .raw   (hooked),
        .rise  (hook_rise)
    );

    in_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_unhook (
        .clk   (clk),
        .reset (reset),
        .raw   (unhooked),
        .rise  (unhook_rise)
    );

    call_state_e   state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [6:0]    elapsed_q, elapsed_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timeout_q, timeout_d;
    logic [3:0]    act1_q, act1_d, act2_q, act2_d;

    logic       tick;
    logic       ev_unhook, ev_hook, ev_write;
    logic [6:0] limit, elapsed_inc;

    assign tick        = (presc_q == PW'(TICKS_PER_SEC - 1));
    assign limit       = mode_limit(mode_q);
    assign elapsed_inc = elapsed_q + 7'd1;

    // Only the highest-priority event of a cycle survives.
    assign ev_unhook = unhook_rise;
    assign ev_hook   = hook_rise & ~unhook_rise;
    assign ev_write  = wr_rise & ~hook_rise & ~unhook_rise;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        elapsed_d = elapsed_q;
        sec_d     = sec_q;
        timeout_d = timeout_q;
        presc_d   = tick ? '0 : presc_q + PW'(1);

        case (state_q)
            StIdle: begin
                if (ev_write) begin
                    mode_d  = mode_in;
                    state_d = StArmed;
                end else if (ev_hook) begin
                    state_d   = StActive;
                    elapsed_d = '0;
                end
            end
            StArmed: begin
                if (ev_hook) begin
                    state_d   = StActive;
                    elapsed_d = '0;
                end else if (ev_write) begin
                    mode_d = mode_in;
                    sec_d  = '0;
                end else if (tick) begin
                    if (sec_q == SW'(ARM_SEC - 1)) state_d = StIdle;
                    else                           sec_d   = sec_q + SW'(1);
                end
            end
            StActive: begin
                if (ev_unhook) begin
                    state_d   = StDone;
                    timeout_d = 1'b0;
                end else if (tick) begin
                    if (elapsed_q != ELAPSED_MAX) elapsed_d = elapsed_inc;
                    if (limit != 7'd0 && elapsed_inc == limit) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
                end
            end
            StDone: begin
                if (ev_hook) begin
                    state_d   = StActive;
                    elapsed_d = '0;
                    timeout_d = 1'b0;
                end else if (tick) begin
                    if (sec_q == SW'(HOLD_SEC - 1)) begin
                        state_d   = StIdle;
                        timeout_d = 1'b0;
                    end else begin
                        sec_d = sec_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            sec_d   = '0;
        end

        case (state_d)
            StIdle: begin
                act1_d = CODE_BLANK;
                act2_d = CODE_BLANK;
            end
            StArmed: begin
                act1_d = CODE_DASH;
                act2_d = CODE_DASH;
            end
            default: begin
                act1_d = 4'(elapsed_d / 7'd10);
                act2_d = 4'(elapsed_d % 7'd10);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            mode_q    <= 2'd0;
            elapsed_q <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            timeout_q <= 1'b0;
            act1_q    <= CODE_BLANK;
            act2_q    <= CODE_BLANK;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            elapsed_q <= elapsed_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            timeout_q <= timeout_d;
            act1_q    <= act1_d;
            act2_q    <= act2_d;
        end
    end

    assign state     = state_q;
    assign mode_code = {2'b00, mode_q};
    assign act1_code = act1_q;
    assign act2_code = act2_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_call_seq_ctrl.sv
// Bench for call_seq_ctrl: directed scenarios pinned with literals, then randomized buttons,
// all checked every cycle against a behavioural model.
module tb_call_seq_ctrl;

    localparam int T    = 10;
    localparam int D    = 4;
    localparam int ARM  = 3;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode_in = 2'd0;
    logic       write_mode = 1'b0, hooked = 1'b0, unhooked = 1'b0;
    logic [1:0] state;
    logic [3:0] mode_code, act1_code, act2_code;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    call_seq_ctrl #(
        .TICKS_PER_SEC  (T),
        .DEBOUNCE_TICKS (D),
        .ARM_SEC        (ARM),
        .HOLD_SEC       (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_in    (mode_in),
        .write_mode (write_mode),
        .hooked     (hooked),
        .unhooked   (unhooked),
        .state      (state),
        .mode_code  (mode_code),
        .act1_code  (act1_code),
        .act2_code  (act2_code),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Model: state 0..3, seconds counted from cycles since the last state change.
    int m_state = 0, m_mode = 0, m_elapsed = 0, m_ticks = 0, m_cyc = 0;
    bit m_timeout = 0;
    // Per input (0 unhooked, 1 hooked, 2 write_mode): raw delay line, run length, level.
    bit h1[3], h2[3], lvl[3], rose[3], last[3];
    int same[3];

    function automatic int limit_of(input int mode);
        case (mode)
            1: return 10;
            2: return 30;
            3: return 60;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit r[3];
        bit ev_un, ev_hk, ev_wr, tk, x;
        int nxt;
        r[0] = unhooked; r[1] = hooked; r[2] = write_mode;
        if (reset) begin
            m_state = 0; m_mode = 0; m_elapsed = 0; m_ticks = 0; m_cyc = 0; m_timeout = 0;
            for (int i = 0; i < 3; i++) begin
                h1[i] = 0; h2[i] = 0; lvl[i] = 0; rose[i] = 0; last[i] = 0; same[i] = 0;
            end
            return;
        end
        ev_un = rose[0];
        ev_hk = rose[1] && !rose[0];
        ev_wr = rose[2] && !rose[1] && !rose[0];
        tk    = ((m_cyc + 1) % T) == 0;
        nxt   = m_state;
        case (m_state)
            0: begin
                if (ev_wr) begin m_mode = int'(mode_in); nxt = 1; end
                else if (ev_hk) begin nxt = 2; m_elapsed = 0; end
            end
            1: begin
                if (ev_hk) begin nxt = 2; m_elapsed = 0; end
                else if (ev_wr) begin m_mode = int'(mode_in); m_ticks = 0; end
                else if (tk) begin m_ticks++; if (m_ticks == ARM) nxt = 0; end
            end
            2: begin
                if (ev_un) begin nxt = 3; m_timeout = 0; end
                else if (tk) begin
                    m_ticks++;
                    m_elapsed = (m_ticks > 99) ? 99 : m_ticks;
                    if (limit_of(m_mode) != 0 && m_ticks == limit_of(m_mode)) begin
                        nxt = 3; m_timeout = 1;
                    end
                end
            end
            default: begin
                if (ev_hk) begin nxt = 2; m_elapsed = 0; m_timeout = 0; end
                else if (tk) begin
                    m_ticks++;
                    if (m_ticks == HOLD) begin nxt = 0; m_timeout = 0; end
                end
            end
        endcase
        if (nxt != m_state) begin m_cyc = 0; m_ticks = 0; end
        else m_cyc++;
        m_state = nxt;
        for (int i = 0; i < 3; i++) begin
            x = h2[i];
            if (x == last[i]) same[i]++;
            else begin same[i] = 1; last[i] = x; end
            rose[i] = 0;
            if (same[i] >= D && x != lvl[i]) begin lvl[i] = x; rose[i] = x; end
            h2[i] = h1[i];
            h1[i] = r[i];
        end
    endtask

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic compare();
        int e1, e2;
        case (m_state)
            0: begin e1 = 15; e2 = 15; end
            1: begin e1 = 10; e2 = 10; end
            default: begin e1 = m_elapsed / 10; e2 = m_elapsed % 10; end
        endcase
        check("state", int'(state), m_state);
        check("mode_code", int'(mode_code), m_mode);
        check("act1_code", int'(act1_code), e1);
        check("act2_code", int'(act2_code), e2);
        check("timeout", int'(timeout), int'(m_timeout));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            compare();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        int len;
        @(negedge clk);
        run(2);
        check("lit_reset_state", int'(state), 0);
        check("lit_reset_act1", int'(act1_code), 15);
        reset = 1'b0;

        // Commit and arm timeout.
        mode_in = 2'd1; write_mode = 1'b1;
        run(7);
        check("lit_commit_state", int'(state), 1);
        check("lit_commit_mode", int'(mode_code), 1);
        check("lit_commit_act1", int'(act1_code), 10);
        check("lit_commit_act2", int'(act2_code), 10);
        run(1); write_mode = 1'b0;
        run(29);
        check("lit_arm_to_state", int'(state), 0);
        check("lit_arm_to_act2", int'(act2_code), 15);

        // Glitch rejection.
        hooked = 1'b1; run(3); hooked = 1'b0; run(10);
        check("lit_glitch_state", int'(state), 0);

        // Limit timeout in mode 1.
        mode_in = 2'd1; write_mode = 1'b1; run(8); write_mode = 1'b0;
        hooked = 1'b1; run(7);
        check("lit_active_state", int'(state), 2);
        check("lit_active_act2", int'(act2_code), 0);
        run(1); hooked = 1'b0; run(99);
        check("lit_limit_state", int'(state), 3);
        check("lit_limit_act1", int'(act1_code), 1);
        check("lit_limit_act2", int'(act2_code), 0);
        check("lit_limit_timeout", int'(timeout), 1);
        run(20);
        check("lit_hold_state", int'(state), 0);
        check("lit_hold_timeout", int'(timeout), 0);

        // Release in mode 0 after 5 s.
        do_reset();
        hooked = 1'b1; run(7); run(1); hooked = 1'b0;
        run(44); unhooked = 1'b1; run(7);
        check("lit_release_state", int'(state), 3);
        check("lit_release_act2", int'(act2_code), 5);
        check("lit_release_timeout", int'(timeout), 0);
        run(1); unhooked = 1'b0; run(30);

        // Simultaneous hooked/unhooked in ACTIVE.
        do_reset();
        hooked = 1'b1; run(8); hooked = 1'b0; run(20);
        hooked = 1'b1; unhooked = 1'b1; run(7);
        check("lit_simul_state", int'(state), 3);
        check("lit_simul_act2", int'(act2_code), 2);
        run(1); hooked = 1'b0; unhooked = 1'b0; run(25);

        // Reset mid-sequence with elapsed 7 in mode 2.
        do_reset();
        mode_in = 2'd2; write_mode = 1'b1; run(8); write_mode = 1'b0;
        hooked = 1'b1; run(8); hooked = 1'b0; run(70);
        check("lit_mid_act2", int'(act2_code), 7);
        reset = 1'b1; run(1);
        check("lit_mid_rst_state", int'(state), 0);
        check("lit_mid_rst_mode", int'(mode_code), 0);
        check("lit_mid_rst_act1", int'(act1_code), 15);
        check("lit_mid_rst_timeout", int'(timeout), 0);
        reset = 1'b0;

        // Randomized buttons, mode values and occasional resets.
        for (int s = 0; s < 500; s++) begin
            mode_in = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                hooked = 1'b0; unhooked = 1'b0; write_mode = 1'b0;
                len = $urandom_range(1, 40);
            end else begin
                hooked     = ($urandom_range(0, 3) == 0);
                unhooked   = ($urandom_range(0, 5) == 0);
                write_mode = ($urandom_range(0, 3) == 0);
                len = $urandom_range(1, 10);
            end
            if (reset) len = 1;
            run(len);
        end
        reset = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
